// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller: FSM state codes and width helpers.
// Optional parity storage is enabled by defining DATA_MEM_PARITY_EN.
package data_mem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word array with byte-enable write port and registered read port.
// With DATA_MEM_PARITY_EN defined, an even-parity bit per byte is stored and checked on read.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  logic                             rd_en,
    input  logic [IDX_W-1:0]                 addr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic [bytes_per_word(DATA_W)-1:0] be,
    output logic [DATA_W-1:0]                rdata,
    output logic                             perr
);

    localparam int BPW = bytes_per_word(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata holds the last read until the next one.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BPW; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic [BPW-1:0] par_mem [DEPTH];
    logic [BPW-1:0] wr_par;
    logic [BPW-1:0] rd_calc;

    always_comb begin
        wr_par  = '0;
        rd_calc = '0;
        for (int i = 0; i < BPW; i++) begin
            wr_par[i]  = ^wdata[8*i +: 8];
            rd_calc[i] = ^mem[addr][8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BPW; i++) begin
                if (be[i]) begin
                    par_mem[addr][i] <= wr_par[i];
                end
            end
        end
        if (rd_en) begin
            perr <= |(rd_calc ^ par_mem[addr]);
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked data memory controller: valid/ready request, LATENCY-cycle response pulse, error flag.
// Define DATA_MEM_PARITY_EN to store and check per-byte parity (parity_err); otherwise it is always 0.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_wdata,
    input  logic [bytes_per_word(DATA_W)-1:0] req_be,
    output logic                              rsp_valid,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic                              rsp_err,
    output logic                              parity_err
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int OFF_W = clog2(BPW);
    localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              err_q;
    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              acc_err;
    logic              data_ok;
    logic [DATA_W-1:0] rd_word;
    logic              rd_perr;

    assign req_ready    = (state == IDLE);
    assign accept       = req_valid && req_ready;
    assign word_idx     = req_addr >> OFF_W;
    assign misaligned   = (req_addr & ADDR_W'(BPW - 1)) != '0;
    assign out_of_range = word_idx >= ADDR_W'(DEPTH);
    assign acc_err      = misaligned || out_of_range;

    // The array is touched only at the accept edge, so a write is committed even if reset follows.
    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .wr_en (accept && req_we && !acc_err),
        .rd_en (accept && !req_we && !acc_err),
        .addr  (word_idx[IDX_W-1:0]),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (rd_word),
        .perr  (rd_perr)
    );

    // WAIT lasts LATENCY-1 cycles so the RESP cycle lands exactly LATENCY cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        err_q <= acc_err;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = (state == RESP);
    assign data_ok    = rsp_valid && !we_q && !err_q;
    assign rsp_err    = rsp_valid && err_q;
    assign rsp_rdata  = data_ok ? rd_word : '0;
    assign parity_err = data_ok && rd_perr;

endmodule
